// File: rtl/taiko_pkg.sv
// Shared constants and types for the drum-note overlay: screen geometry,
// note colours and the one-bit note kind.
package taiko_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_DON = 3'b100;
  localparam logic [2:0] COL_KA  = 3'b001;

  typedef enum logic {
    KIND_DON = 1'b0,
    KIND_KA  = 1'b1
  } note_kind_e;

  typedef struct packed {
    logic       active;
    note_kind_e kind;
    logic [7:0] x;
  } slot_t;

  function automatic logic [2:0] kind_color(input note_kind_e kind);
    return (kind == KIND_KA) ? COL_KA : COL_DON;
  endfunction

endpackage

// File: rtl/note_slot.sv
// One note slot: active/kind/x registers plus the per-pixel coverage test
// and the judgement-window and miss-position flags.
module note_slot
  import taiko_pkg::*;
#(
  parameter int NOTE_W  = 8,
  parameter int NOTE_H  = 8,
  parameter int LANE_Y  = 40,
  parameter int SPAWN_X = 152,
  parameter int HIT_X   = 20,
  parameter int WINDOW  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       load_kind,
  input  logic       dec,
  input  logic [7:0] px,
  input  logic [6:0] py,
  output logic       active,
  output note_kind_e kind,
  output logic       covers,
  output logic       in_window,
  output logic       at_miss
);

  localparam logic [8:0] SPAN      = 9'(NOTE_W - 1);
  localparam logic [7:0] WIN_LO    = 8'(HIT_X - WINDOW);
  localparam logic [7:0] WIN_HI    = 8'(HIT_X + WINDOW);
  localparam logic [7:0] MISS_X    = 8'(HIT_X - WINDOW - 1);
  localparam logic [7:0] LANE_TOP  = 8'(LANE_Y);
  localparam logic [7:0] LANE_BOT  = 8'(LANE_Y + NOTE_H - 1);

  slot_t      slot_reg;
  logic [8:0] left_edge;
  logic [8:0] right_edge;
  logic [8:0] px_wide;
  logic [7:0] py_wide;

  // Widen before adding the sprite span so the right edge cannot wrap.
  always_comb begin
    left_edge  = {1'b0, slot_reg.x};
    right_edge = left_edge + SPAN;
    px_wide    = {1'b0, px};
    py_wide    = {1'b0, py};
  end

  assign active    = slot_reg.active;
  assign kind      = slot_reg.kind;
  assign covers    = slot_reg.active
                     && (px_wide >= left_edge) && (px_wide <= right_edge)
                     && (py_wide >= LANE_TOP) && (py_wide <= LANE_BOT);
  assign in_window = slot_reg.active && (slot_reg.x >= WIN_LO) && (slot_reg.x <= WIN_HI);
  assign at_miss   = slot_reg.active && (slot_reg.x == MISS_X);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg.active <= 1'b0;
      slot_reg.kind   <= KIND_DON;
      slot_reg.x      <= '0;
    end else if (clear) begin
      slot_reg.active <= 1'b0;
    end else if (load) begin
      slot_reg.active <= 1'b1;
      slot_reg.kind   <= note_kind_e'(load_kind);
      slot_reg.x      <= 8'(SPAWN_X);
    end else if (dec) begin
      slot_reg.x      <= slot_reg.x - 8'd1;
    end
  end

endmodule

// File: rtl/note_compositor.sv
// Overlays scrolling drum notes on the background raster and manages note
// lifetime: spawn, per-frame scroll, hit judgement and miss detection.
module note_compositor
  import taiko_pkg::*;
#(
  parameter int NUM_NOTES = 4,
  parameter int NOTE_W    = 8,
  parameter int NOTE_H    = 8,
  parameter int LANE_Y    = 40,
  parameter int SPAWN_X   = 152,
  parameter int HIT_X     = 20,
  parameter int WINDOW    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] bg_x,
  input  logic [6:0] bg_y,
  input  logic [2:0] bg_color,
  input  logic       spawn,
  input  logic       spawn_kind,
  input  logic       hit,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_color,
  output logic       plot,
  output logic       frame_tick,
  output logic       hit_ok,
  output logic       hit_bad,
  output logic       note_miss,
  output logic       spawn_drop
);

  localparam logic [NUM_NOTES-1:0] LSB = NUM_NOTES'(1);

  logic [NUM_NOTES-1:0] active_vec;
  logic [NUM_NOTES-1:0] cover_vec;
  logic [NUM_NOTES-1:0] window_vec;
  logic [NUM_NOTES-1:0] miss_pos_vec;
  note_kind_e           kind_vec [NUM_NOTES];

  logic [NUM_NOTES-1:0] free_vec;
  logic [NUM_NOTES-1:0] spawn_sel;
  logic [NUM_NOTES-1:0] hit_sel;
  logic [NUM_NOTES-1:0] cover_sel;
  logic [NUM_NOTES-1:0] miss_vec;
  logic [NUM_NOTES-1:0] clear_vec;
  logic [NUM_NOTES-1:0] load_vec;
  logic [NUM_NOTES-1:0] dec_vec;
  logic [2:0]           color_next;
  logic                 last_pixel;

  logic [7:0] out_x_reg;
  logic [6:0] out_y_reg;
  logic [2:0] out_color_reg;
  logic       started_reg;
  logic       plot_reg;
  logic       frame_tick_reg;
  logic       hit_ok_reg;
  logic       hit_bad_reg;
  logic       note_miss_reg;
  logic       spawn_drop_reg;

  generate
    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_slot
      note_slot #(
        .NOTE_W  (NOTE_W),
        .NOTE_H  (NOTE_H),
        .LANE_Y  (LANE_Y),
        .SPAWN_X (SPAWN_X),
        .HIT_X   (HIT_X),
        .WINDOW  (WINDOW)
      ) u_slot (
        .clk       (CLOCK_50),
        .rst       (reset),
        .clear     (clear_vec[gi]),
        .load      (load_vec[gi]),
        .load_kind (spawn_kind),
        .dec       (dec_vec[gi]),
        .px        (bg_x),
        .py        (bg_y),
        .active    (active_vec[gi]),
        .kind      (kind_vec[gi]),
        .covers    (cover_vec[gi]),
        .in_window (window_vec[gi]),
        .at_miss   (miss_pos_vec[gi])
      );
    end
  endgenerate

  // All selections use pre-update slot state; v & (~v + 1) isolates the
  // lowest set bit, giving lowest-index priority.
  always_comb begin
    free_vec   = ~active_vec;
    spawn_sel  = free_vec & (~free_vec + LSB);
    hit_sel    = hit ? (window_vec & (~window_vec + LSB)) : '0;
    miss_vec   = frame_tick_reg ? (miss_pos_vec & ~hit_sel) : '0;
    dec_vec    = frame_tick_reg ? (active_vec & ~miss_pos_vec & ~hit_sel) : '0;
    clear_vec  = hit_sel | miss_vec;
    load_vec   = spawn ? spawn_sel : '0;
    cover_sel  = cover_vec & (~cover_vec + LSB);
    color_next = bg_color;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (cover_sel[i]) begin
        color_next = kind_color(kind_vec[i]);
      end
    end
    last_pixel = (bg_x == 8'(SCREEN_W - 1)) && (bg_y == 7'(SCREEN_H - 1));
  end

  // plot trails started_reg by one cycle so the pixel sampled across the
  // reset release is never written.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_color_reg  <= '0;
      started_reg    <= 1'b0;
      plot_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
      hit_ok_reg     <= 1'b0;
      hit_bad_reg    <= 1'b0;
      note_miss_reg  <= 1'b0;
      spawn_drop_reg <= 1'b0;
    end else begin
      out_x_reg      <= bg_x;
      out_y_reg      <= bg_y;
      out_color_reg  <= color_next;
      started_reg    <= 1'b1;
      plot_reg       <= started_reg;
      frame_tick_reg <= last_pixel;
      hit_ok_reg     <= hit && (|window_vec);
      hit_bad_reg    <= hit && !(|window_vec);
      note_miss_reg  <= |miss_vec;
      spawn_drop_reg <= spawn && !(|free_vec);
    end
  end

  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign out_color  = out_color_reg;
  assign plot       = plot_reg;
  assign frame_tick = frame_tick_reg;
  assign hit_ok     = hit_ok_reg;
  assign hit_bad    = hit_bad_reg;
  assign note_miss  = note_miss_reg;
  assign spawn_drop = spawn_drop_reg;

endmodule

// File: tb/tb_note_compositor.sv
// Bench for note_compositor: directed scenarios plus random traffic, checked
// against a list-of-notes model that applies the lifetime rules each cycle.
module tb_note_compositor;

  localparam int N       = 4;
  localparam int NW      = 8;
  localparam int NH      = 8;
  localparam int LANE_Y  = 40;
  localparam int SPAWN_X = 152;
  localparam int HIT_LO  = 18;
  localparam int HIT_HI  = 22;
  localparam int MISS_X  = 17;
  localparam logic [2:0] BG = 3'b010;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bg_x = '0;
  logic [6:0] bg_y = '0;
  logic [2:0] bg_color = '0;
  logic       spawn = 1'b0;
  logic       spawn_kind = 1'b0;
  logic       hit = 1'b0;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_color;
  logic       plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: a plain list of notes.
  bit m_act [N];
  bit m_kind[N];
  int m_x   [N];
  bit m_tick;
  bit m_started;

  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_color;
  logic e_plot, e_tick, e_ok, e_bad, e_miss, e_drop;

  note_compositor dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .bg_x       (bg_x),
    .bg_y       (bg_y),
    .bg_color   (bg_color),
    .spawn      (spawn),
    .spawn_kind (spawn_kind),
    .hit        (hit),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_color  (out_color),
    .plot       (plot),
    .frame_tick (frame_tick),
    .hit_ok     (hit_ok),
    .hit_bad    (hit_bad),
    .note_miss  (note_miss),
    .spawn_drop (spawn_drop)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2:0] model_pixel(input int px, input int py, input logic [2:0] bc);
    for (int i = 0; i < N; i++) begin
      if (m_act[i] && px >= m_x[i] && px <= m_x[i] + NW - 1 && py >= LANE_Y && py <= LANE_Y + NH - 1)
        return m_kind[i] ? 3'b001 : 3'b100;
    end
    return bc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_kind[i] = 0; m_x[i] = 0;
    end
    m_tick = 0;
    m_started = 0;
  endtask

  // Drive one pixel/event cycle (called at a negedge), predict the outputs
  // visible after the next rising edge, advance the model, return at negedge.
  task automatic step(input int bx, input int by, input logic [2:0] bc,
                      input bit sp, input bit sk, input bit ht);
    int hit_i, free_i;
    bit n_act[N];
    bit n_kind[N];
    int n_x[N];
    bg_x = 8'(bx); bg_y = 7'(by); bg_color = bc;
    spawn = sp; spawn_kind = sk; hit = ht;
    e_x = 8'(bx); e_y = 7'(by);
    e_color = model_pixel(bx, by, bc);
    e_plot = m_started;
    e_tick = (bx == 159 && by == 119);
    hit_i = -1; free_i = -1;
    for (int i = 0; i < N; i++) begin
      if (hit_i < 0 && m_act[i] && m_x[i] >= HIT_LO && m_x[i] <= HIT_HI) hit_i = i;
      if (free_i < 0 && !m_act[i]) free_i = i;
    end
    e_ok = ht && hit_i >= 0;
    e_bad = ht && hit_i < 0;
    e_drop = sp && free_i < 0;
    e_miss = 0;
    n_act = m_act; n_kind = m_kind; n_x = m_x;
    for (int i = 0; i < N; i++) begin
      if (ht && i == hit_i) n_act[i] = 0;
      else if (m_tick && m_act[i]) begin
        if (m_x[i] == MISS_X) begin n_act[i] = 0; e_miss = 1; end
        else n_x[i] = m_x[i] - 1;
      end
    end
    if (sp && free_i >= 0) begin
      n_act[free_i] = 1; n_kind[free_i] = sk; n_x[free_i] = SPAWN_X;
    end
    m_act = n_act; m_kind = n_kind; m_x = n_x;
    m_tick = e_tick;
    m_started = 1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic tick();
    step(159, 119, BG, 0, 0, 0);
    step(0, 0, BG, 0, 0, 0);
  endtask

  task automatic probe(input int px, input int py);
    step(px, py, BG, 0, 0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bg_x = 8'd77; bg_y = 7'd40; bg_color = 3'b111; spawn = 1; hit = 1;
    repeat (2) @(negedge CLOCK_50);
    spawn = 0; hit = 0; bg_x = 0; bg_y = 0; bg_color = 0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bg_x = 8'd155; bg_y = 7'd44; bg_color = 3'b111; spawn = 1; hit = 1;
    @(negedge CLOCK_50);
    n_cmp++;
    if ({plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color});
    end
    spawn = 0; hit = 0;
    reset = 1'b0;
    model_reset();
    step(3, 5, BG, 0, 0, 0);
    n_cmp++;
    if (plot !== 1'b0) begin n_bad++; $display("FAIL plot_first_cycle got=%b want=0", plot); end
    step(4, 5, BG, 0, 0, 0);
    n_cmp++;
    if (plot !== 1'b1) begin n_bad++; $display("FAIL plot_second_cycle got=%b want=1", plot); end
    n_cmp++;
    if ({out_x, out_y, out_color} !== {8'd4, 7'd5, BG}) begin
      n_bad++; $display("FAIL first_pixel got=%h want=%h", {out_x, out_y, out_color}, {8'd4, 7'd5, BG});
    end
  endtask

  task automatic test_raster();
    int ticks = 0;
    apply_reset();
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        step(x, y, BG, 0, 0, 0);
        ticks += int'(frame_tick);
        n_cmp++;
        if ({plot, frame_tick, out_x, out_y, out_color} !== {e_plot, e_tick, e_x, e_y, e_color} || out_color !== BG) begin
          n_bad++;
          $display("FAIL raster_pixel x=%0d y=%0d got=%h want=%h", x, y,
                   {plot, frame_tick, out_x, out_y, out_color}, {e_plot, e_tick, e_x, e_y, e_color});
        end
      end
    end
    step(0, 0, BG, 0, 0, 0);
    n_cmp++;
    if (frame_tick !== 1'b0 || ticks != 1) begin
      n_bad++; $display("FAIL frame_tick_count got=%0d still_high=%b want=1", ticks, frame_tick);
    end
  endtask

  task automatic test_spawn_scroll();
    logic [2:0] bc;
    apply_reset();
    step(0, 0, BG, 1, 0, 0);
    for (int y = LANE_Y - 1; y <= LANE_Y + NH; y++) begin
      for (int x = 140; x < 160; x++) begin
        bc = 3'($urandom_range(0, 7));
        step(x, y, bc, 0, 0, 0);
        n_cmp++;
        if (out_color !== e_color || (y >= 40 && y <= 47 && x >= 152 && out_color !== 3'b100)) begin
          n_bad++; $display("FAIL spawn_sprite x=%0d y=%0d got=%b want=%b", x, y, out_color, e_color);
        end
      end
    end
    repeat (10) tick();
    probe(142, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL scroll_left_edge got=%b want=100", out_color); end
    probe(149, 47);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL scroll_right_edge got=%b want=100", out_color); end
    probe(150, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL scroll_past_right got=%b want=%b", out_color, BG); end
    probe(141, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL scroll_past_left got=%b want=%b", out_color, BG); end
    probe(145, 48);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL lane_bottom got=%b want=%b", out_color, BG); end
  endtask

  task automatic test_miss();
    apply_reset();
    step(0, 0, BG, 1, 0, 0);
    repeat (135) tick();
    probe(17, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL miss_pos_left got=%b want=100", out_color); end
    probe(16, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL miss_pos_outside got=%b want=%b", out_color, BG); end
    probe(24, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL miss_pos_right got=%b want=100", out_color); end
    step(159, 119, BG, 0, 0, 0);
    n_cmp++; if (note_miss !== 1'b0) begin n_bad++; $display("FAIL miss_early got=%b want=0", note_miss); end
    step(0, 0, BG, 0, 0, 0);
    n_cmp++; if (note_miss !== 1'b1) begin n_bad++; $display("FAIL miss_pulse got=%b want=1", note_miss); end
    step(0, 0, BG, 0, 0, 0);
    n_cmp++; if (note_miss !== 1'b0) begin n_bad++; $display("FAIL miss_single got=%b want=0", note_miss); end
    probe(17, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL miss_erased got=%b want=%b", out_color, BG); end
    step(0, 0, BG, 1, 1, 0);
    n_cmp++; if (spawn_drop !== 1'b0) begin n_bad++; $display("FAIL miss_reuse_drop got=%b want=0", spawn_drop); end
    probe(159, 40);
    n_cmp++; if (out_color !== 3'b001) begin n_bad++; $display("FAIL miss_reuse_ka got=%b want=001", out_color); end
  endtask

  task automatic test_hit_window();
    int tgt;
    for (int t = 0; t < 3; t++) begin
      tgt = (t == 0) ? 18 : (t == 1) ? 20 : 22;
      apply_reset();
      step(0, 0, BG, 1, 0, 0);
      repeat (SPAWN_X - tgt) tick();
      probe(tgt, 40);
      n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL hit_pre_draw x=%0d got=%b want=100", tgt, out_color); end
      step(0, 0, BG, 0, 0, 1);
      n_cmp++;
      if ({hit_ok, hit_bad} !== 2'b10 || {hit_ok, hit_bad} !== {e_ok, e_bad}) begin
        n_bad++; $display("FAIL hit_in_window x=%0d got=%b want=10", tgt, {hit_ok, hit_bad});
      end
      probe(tgt, 40);
      n_cmp++;
      if (out_color !== BG || hit_ok !== 1'b0) begin
        n_bad++; $display("FAIL hit_erase x=%0d got=%b/%b want=%b/0", tgt, out_color, hit_ok, BG);
      end
    end
    apply_reset();
    step(0, 0, BG, 1, 0, 0);
    repeat (SPAWN_X - 23) tick();
    step(0, 0, BG, 0, 0, 1);
    n_cmp++; if ({hit_ok, hit_bad} !== 2'b01) begin n_bad++; $display("FAIL hit_outside got=%b want=01", {hit_ok, hit_bad}); end
    probe(23, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL hit_outside_kept got=%b want=100", out_color); end
    apply_reset();
    step(0, 0, BG, 0, 0, 1);
    n_cmp++; if ({hit_ok, hit_bad} !== 2'b01) begin n_bad++; $display("FAIL hit_empty got=%b want=01", {hit_ok, hit_bad}); end
  endtask

  task automatic test_full_and_overlap();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, BG, 1, k[0], 0);
      n_cmp++;
      if (spawn_drop !== 1'(k == 4)) begin
        n_bad++; $display("FAIL spawn_drop_n%0d got=%b want=%b", k, spawn_drop, 1'(k == 4));
      end
    end
    apply_reset();
    step(0, 0, BG, 1, 0, 0);
    tick();
    step(0, 0, BG, 1, 1, 0);
    probe(152, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL overlap_priority got=%b want=100", out_color); end
    probe(159, 40);
    n_cmp++; if (out_color !== 3'b001) begin n_bad++; $display("FAIL overlap_ka_only got=%b want=001", out_color); end
    probe(150, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL overlap_outside got=%b want=%b", out_color, BG); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    step(0, 0, BG, 1, 0, 0);
    repeat (3) tick();
    step(0, 0, BG, 1, 0, 0);
    repeat (50) tick();
    step(0, 0, BG, 1, 0, 0);
    repeat (82) tick();
    // Slots now at x=17, 20, 70; slot 3 free.
    step(159, 119, BG, 0, 0, 0);
    step(0, 0, BG, 1, 1, 1);
    n_cmp++;
    if ({hit_ok, hit_bad, note_miss, spawn_drop} !== 4'b1010 ||
        {hit_ok, hit_bad, note_miss, spawn_drop} !== {e_ok, e_bad, e_miss, e_drop}) begin
      n_bad++; $display("FAIL same_cycle_pulses got=%b want=1010", {hit_ok, hit_bad, note_miss, spawn_drop});
    end
    probe(151, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL spawn_not_scrolled got=%b want=%b", out_color, BG); end
    probe(152, 40);
    n_cmp++; if (out_color !== 3'b001) begin n_bad++; $display("FAIL same_cycle_spawn got=%b want=001", out_color); end
    probe(69, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL same_cycle_scroll got=%b want=100", out_color); end
    probe(68, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL same_cycle_scroll_edge got=%b want=%b", out_color, BG); end
    probe(20, 40);
    n_cmp++; if (out_color !== BG) begin n_bad++; $display("FAIL same_cycle_freed got=%b want=%b", out_color, BG); end
    step(0, 0, BG, 1, 0, 0);
    probe(152, 40);
    n_cmp++; if (out_color !== 3'b100) begin n_bad++; $display("FAIL freed_slot_reused got=%b want=100", out_color); end
    step(0, 0, BG, 1, 0, 0);
    n_cmp++; if (spawn_drop !== 1'b0) begin n_bad++; $display("FAIL last_free_slot got=%b want=0", spawn_drop); end
    step(0, 0, BG, 1, 0, 0);
    n_cmp++; if (spawn_drop !== 1'b1) begin n_bad++; $display("FAIL refill_drop got=%b want=1", spawn_drop); end
  endtask

  task automatic test_random();
    int bx, by;
    bit sp, sk, ht;
    logic [2:0] bc;
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin bx = 159; by = 119; end
      else begin bx = int'($urandom_range(0, 159)); by = int'($urandom_range(36, 51)); end
      sp = ($urandom_range(0, 39) == 0);
      sk = 1'($urandom_range(0, 1));
      ht = ($urandom_range(0, 31) == 0);
      bc = 3'($urandom_range(0, 7));
      step(bx, by, bc, sp, sk, ht);
      n_cmp++;
      if ({plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color} !==
          {e_plot, e_tick, e_ok, e_bad, e_miss, e_drop, e_x, e_y, e_color}) begin
        n_bad++;
        $display("FAIL random_cycle c=%0d got=%h want=%h", c,
                 {plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color},
                 {e_plot, e_tick, e_ok, e_bad, e_miss, e_drop, e_x, e_y, e_color});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] bc;
    apply_reset();
    repeat (3) step(0, 0, BG, 1, 0, 0);
    repeat (10) tick();
    step(0, 0, BG, 0, 0, 1);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got=%h want=0",
               {plot, frame_tick, hit_ok, hit_bad, note_miss, spawn_drop, out_x, out_y, out_color});
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
    for (int y = LANE_Y; y < LANE_Y + NH; y++) begin
      for (int x = 136; x < 160; x++) begin
        bc = 3'($urandom_range(0, 7));
        step(x, y, bc, 0, 0, 0);
        n_cmp++;
        if (out_color !== bc) begin
          n_bad++; $display("FAIL mid_reset_no_notes x=%0d y=%0d got=%b want=%b", x, y, out_color, bc);
        end
      end
    end
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_raster();
    test_spawn_scroll();
    test_miss();
    test_hit_window();
    test_full_and_overlap();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_compositor.md
# note_compositor

Downstream stage of the background scanner: consumes its raster pixel stream (x, y, 3-bit colour, one pixel per clock over 160×120) and overlays up to NUM_NOTES scrolling drum notes on a single lane. It produces the plot/x/y/colour stream for the VGA adapter. It also owns note lifetime: spawn, per-frame scroll, hit judgement and miss detection.

## Interface
- NUM_NOTES, 4, note slots (1..8)
- NOTE_W, 8, note sprite width in pixels
- NOTE_H, 8, note sprite height in pixels
- LANE_Y, 40, top row of the note lane
- SPAWN_X, 152, x of a newly spawned note (SPAWN_X+NOTE_W-1 ≤ 159)
- HIT_X, 20, centre of the judgement window
- WINDOW, 2, half-width of the judgement window; MISS_X = HIT_X-WINDOW-1
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- bg_x  in  8  upstream pixel x, 0..159
- bg_y  in  7  upstream pixel y, 0..119
- bg_color  in  3  upstream pixel colour
- spawn  in  1  one-cycle pulse: create a note
- spawn_kind  in  1  0 = don (red), 1 = ka (blue)
- hit  in  1  one-cycle pulse: player strike
- out_x  out  8  registered pixel x
- out_y  out  7  registered pixel y
- out_color  out  3  registered composed colour
- plot  out  1  write enable to the VGA adapter
- frame_tick  out  1  one-cycle pulse after the last pixel of a frame
- hit_ok  out  1  pulse: strike matched a note
- hit_bad  out  1  pulse: strike matched nothing
- note_miss  out  1  pulse: a note left the window unhit
- spawn_drop  out  1  pulse: spawn ignored, all slots busy

## Operation
- Per slot: active bit, kind bit, 8-bit x. Reset clears all slots.
- Compose: a slot covers the pixel if it is active, nx ≤ bg_x ≤ nx+NOTE_W-1 and LANE_Y ≤ bg_y ≤ LANE_Y+NOTE_H-1. Comparisons are 9-bit, so there is no wrap.
- Covered pixels take 3'b100 for don and 3'b001 for ka. Otherwise out_color = bg_color.
- When slots overlap, the lowest covering index wins.
- Frame end: bg_x==159 && bg_y==119 is registered into frame_tick, which goes high the following cycle.
- Scroll: on a frame_tick cycle, each active slot with x==MISS_X is freed and note_miss pulses once (even if several slots free). Every other active slot does x ← x-1.
- Spawn: the lowest-index free slot is set to active, kind = spawn_kind, x = SPAWN_X. If no slot is free, spawn_drop pulses and state is unchanged.
- Hit: the lowest-index active slot with HIT_X-WINDOW ≤ x ≤ HIT_X+WINDOW is freed and hit_ok pulses. If none matches, hit_bad pulses.
- Simultaneous events are all judged on pre-update state:
  - A hit-freed slot does not also miss or scroll.
  - A newly spawned slot is not scrolled that cycle.
  - A slot freed by hit or miss in that cycle is not eligible for spawn in the same cycle.

## Timing
- Pixel path latency is 1 cycle: out_x/out_y/out_color at cycle n+1 reflect bg_* and slot state at cycle n.
- plot is 0 in reset and for the first cycle after release, then 1 every cycle.
- All outputs reset to 0.
- Event pulses (hit_ok, hit_bad, note_miss, spawn_drop) are registered, appear 1 cycle after the cause, and are never high for 2 consecutive cycles from a single cause.
- Slot updates take effect at the edge after the event; the next pixel drawn uses the new state.
- Reset mid-frame clears slots and pulses immediately. The raster resumes from whatever bg_x/bg_y arrive.

## Structure
- Shared package taiko_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - colour constants COL_DON=3'b100, COL_KA=3'b001
  - kind encoding
- Sub-module note_slot: holds one slot's registers, the coverage compare, the in-window and at-MISS_X flags, and the clear/load/decrement controls. The compositor instantiates NUM_NOTES copies.
- Priority encoders for free-slot, hit and cover selection live in note_compositor.

## Test plan
- Reset, then raster with bg_color=3'b010 and no notes: out_color==3'b010 every pixel, 1-cycle delayed; plot rises on the 2nd post-reset cycle; frame_tick pulses once per 19200 cycles.
- Spawn a don: pixels x 152..159, y 40..47 read 3'b100. After 10 frame_ticks the sprite spans x 142..149.
- Spawn, then let 135 frames elapse without a hit: note reaches x=17, note_miss pulses at the next frame_tick, and the slot is reusable.
- Hit when the note x is 18, 20 and 22: hit_ok each time and the sprite disappears. Hit at x=23 or with no notes: hit_bad and state unchanged.
- Issue 5 spawns with NUM_NOTES=4: 5th gives spawn_drop. Spawn, hit and frame_tick in the same cycle follow the same-cycle ordering rules.
- Overlapping don (slot 0) and ka (slot 1) over the same pixel: red drawn. Assert reset mid-frame: all pulses are 0 and no notes are drawn afterwards.
